mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide responder for the MIPS datapath.
- The control unit initiates an operation with a one-cycle start pulse. This block iterates for a fixed 32 cycles, then answers with a one-cycle done pulse and results held in HI/LO.
- Serves mult/div; mfhi/mflo read hi/lo directly.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request pulse from control unit; sampled only in IDLE
- op  in  1  0 = mult, 1 = div
- a  in  WIDTH  multiplicand / dividend (signed)
- b  in  WIDTH  multiplier / divisor (signed)
- busy  out  1  high while iterating
- done  out  1  one-cycle completion pulse
- div_zero  out  1  high with done when div had b = 0; held until next accepted start
- hi  out  WIDTH  mult: product[63:32]; div: remainder
- lo  out  WIDTH  mult: product[31:0]; div: quotient

Behaviour:
- Reset (synchronous, active-high): on a clock edge with reset=1, state <= IDLE; busy, done, div_zero, hi, lo, counter and internal registers <= 0. Reset overrides everything, including mid-operation: the operation is discarded and no done is produced.
- States: IDLE, MULT, DIV, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1, op=0 -> MULT: latch |a| and |b|, latch the product sign a[31]^b[31], clear the 64-bit accumulator and counter, clear div_zero.
  - start=1, op=1, b!=0 -> DIV: latch |a| and |b|; quotient sign a[31]^b[31]; remainder sign a[31]; clear div_zero.
  - start=1, op=1, b==0 -> DONE directly; div_zero <= 1; hi and lo unchanged.
- Timing: start sampled at the end of cycle 0. Cycles 1..32: busy=1, one iteration per cycle. Counter runs 0..31, and the last iteration occurs when counter==31.
- MULT iteration: unsigned shift-add. If multiplier LSB is 1, add the multiplicand to the upper accumulator half; then shift right one. On the last iteration, the sign-corrected 64-bit result is registered into {hi,lo} -> DONE.
- DIV iteration: restoring division.
  - Shift {rem,quo} left one; trial = rem - divisor (33-bit compare).
  - If non-negative, rem <= trial and quotient LSB <= 1.
  - On the last iteration, register into lo the quotient negated if its sign bit is set, and into hi the remainder negated if its sign bit is set -> DONE.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
- DONE (cycle 33, or cycle 1 for div-by-zero): done=1, busy=0; next state IDLE unconditionally. start is ignored in DONE.
- start while busy or in DONE: ignored; op, a and b are not re-sampled.
- Operands are latched at acceptance; later changes to a/b/op have no effect.
- hi, lo and div_zero hold their values until the next accepted start completes (hi/lo) or is accepted (div_zero).
- 0x80000000 / -1: the natural magnitude result wraps, giving lo=0x80000000, hi=0. No overflow flag.
- All arithmetic is modulo 2^WIDTH per half. Magnitude of 0x80000000 is 0x80000000, treated as unsigned 32-bit.

Decomposition:
- Package mult_div_pkg:
  - enum md_state_t {IDLE, MULT, DIV, DONE}
  - enum md_op_t {OP_MULT=0, OP_DIV=1}
  - localparam ITER = 32
- One natural sub-module, div_step: combinational restoring step taking rem, quo and divisor, and returning the next rem and quo. Instantiated once inside mult_div_unit.
- The multiply path stays inline.

Test Plan:
- mult a=7, b=0xFFFFFFFD (-3), start in cycle 0 -> busy cycles 1..32; cycle 33 done=1 with hi=0xFFFFFFFF, lo=0xFFFFFFEB; cycle 34 done=0.
- mult a=b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001; div_zero=0.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), done in cycle 33.
- div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Second case: prior hi/lo=5/6, then div a=9, b=0 -> done and div_zero in cycle 1, hi=5, lo=6 unchanged.
- mult started; start re-pulsed in cycle 5 with new operands -> ignored, original result delivered in cycle 33.
- mult started, reset=1 in cycle 10 -> cycle 11 busy=0, hi=lo=0, no done pulse; a new start afterwards completes normally 33 cycles later.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
package mult_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } md_op_t;

  localparam int ITER = 32;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   rem_wide;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // The shifted remainder can reach WIDTH+1 bits when the divisor is >= 2^(WIDTH-1).
  always_comb begin
    rem_wide = {rem, quo[WIDTH-1]};
    fits     = rem_wide >= {1'b0, divisor};
    diff     = rem_wide[WIDTH-1:0] - divisor;
    rem_next = fits ? diff : rem_wide[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide: magnitude iteration for WIDTH cycles, sign fix on the last step.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_t        state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic             neg_res;
  logic             neg_rem;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               last;
  logic [WIDTH:0]     mult_sum;
  logic [2*WIDTH-1:0] mult_acc;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   div_quo;

  // work_hi/work_lo hold the accumulator halves for mult and remainder/quotient for div.
  always_comb begin
    abs_a       = a[WIDTH-1] ? -a : a;
    abs_b       = b[WIDTH-1] ? -b : b;
    last        = count == CW'(WIDTH - 1);
    mult_sum    = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag_b} : '0);
    mult_acc    = {mult_sum, work_lo[WIDTH-1:1]};
    prod_signed = neg_res ? -mult_acc : mult_acc;
    busy        = (state == MULT) || (state == DIV);
    done        = state == DONE;
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (work_hi),
    .quo      (work_lo),
    .divisor  (mag_b),
    .rem_next (div_rem),
    .quo_next (div_quo)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      mag_b    <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Divide by zero skips iteration entirely and leaves hi/lo untouched.
            if (op == OP_DIV && b == '0) begin
              div_zero <= 1'b1;
              state    <= DONE;
            end else begin
              div_zero <= 1'b0;
              mag_b    <= abs_b;
              work_lo  <= abs_a;
              work_hi  <= '0;
              count    <= '0;
              neg_res  <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_rem  <= a[WIDTH-1];
              state    <= (op == OP_DIV) ? DIV : MULT;
            end
          end
        end
        MULT: begin
          work_hi <= mult_acc[2*WIDTH-1:WIDTH];
          work_lo <= mult_acc[WIDTH-1:0];
          count   <= count + 1'b1;
          if (last) begin
            hi    <= prod_signed[2*WIDTH-1:WIDTH];
            lo    <= prod_signed[WIDTH-1:0];
            state <= DONE;
          end
        end
        DIV: begin
          work_hi <= div_rem;
          work_lo <= div_quo;
          count   <= count + 1'b1;
          if (last) begin
            lo    <= neg_res ? -div_quo : div_quo;
            hi    <= neg_rem ? -div_rem : div_rem;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic reference model checked every cycle plus literal expectations.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int t0 = 0;

  // Reference model state: remaining busy cycles, pending result, visible outputs.
  int          m_left = 0;
  bit          m_done = 1'b0;
  bit          model_valid = 1'b0;
  logic        exp_dz = 1'b0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [31:0] pend_hi = '0;
  logic [31:0] pend_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  // Model: signed 64-bit arithmetic, result visible after 32 busy cycles.
  always @(posedge clock) begin
    longint sa, sb, p, q, r;
    cyc++;
    if (reset) begin
      m_left = 0;
      m_done = 1'b0;
      exp_dz = 1'b0;
      exp_hi = '0;
      exp_lo = '0;
      model_valid = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        exp_hi = pend_hi;
        exp_lo = pend_lo;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op && b == 32'd0) begin
        m_done = 1'b1;
        exp_dz = 1'b1;
      end else begin
        exp_dz = 1'b0;
        m_left = 32;
        if (!op) begin
          p = sa * sb;
          pend_hi = p[63:32];
          pend_lo = p[31:0];
        end else begin
          q = sa / sb;
          r = sa % sb;
          pend_hi = r[31:0];
          pend_lo = q[31:0];
        end
      end
    end
  end

  always @(negedge clock) begin
    if (model_valid) begin
      checkOutput("cyc_busy", 32'(busy), 32'(m_left > 0));
      checkOutput("cyc_done", 32'(done), 32'(m_done));
      checkOutput("cyc_div_zero", 32'(div_zero), 32'(exp_dz));
      checkOutput("cyc_hi", hi, exp_hi);
      checkOutput("cyc_lo", lo, exp_lo);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Presents one start pulse, then scrambles inputs to prove they were latched.
  task automatic applyStimulus(input logic o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    step();
    t0    = cyc;
    start = 1'b0;
    op    = ~o;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic waitDone(inout int n);
    while (done !== 1'b1 && n < 40) begin
      step();
      n = cyc - t0 + 1;
    end
  endtask

  task automatic runOp(input string name, input logic o, input logic [31:0] av, input logic [31:0] bv,
                       input int want_cyc, input logic [31:0] want_hi, input logic [31:0] want_lo,
                       input logic want_dz);
    int n;
    applyStimulus(o, av, bv);
    n = 1;
    waitDone(n);
    checkOutput({name, "_cycle"}, 32'(n), 32'(want_cyc));
    checkOutput({name, "_hi"}, hi, want_hi);
    checkOutput({name, "_lo"}, lo, want_lo);
    checkOutput({name, "_div_zero"}, 32'(div_zero), 32'(want_dz));
    checkOutput({name, "_model_hi"}, exp_hi, want_hi);
    checkOutput({name, "_model_lo"}, exp_lo, want_lo);
    step();
    checkOutput({name, "_done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    reset = 1'b0;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_div_zero", 32'(div_zero), 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);

    runOp("mult_7_m3", 1'b0, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    runOp("mult_max", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 33, 32'h3FFFFFFF, 32'h00000001, 1'b0);
    runOp("mult_m5_m6", 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA, 33, 32'h0, 32'd30, 1'b0);
    runOp("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    runOp("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 33, 32'd1, 32'hFFFFFFFD, 1'b0);
    runOp("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000, 1'b0);
    runOp("div_47_7", 1'b1, 32'd47, 32'd7, 33, 32'd5, 32'd6, 1'b0);
    runOp("div_by_zero", 1'b1, 32'd9, 32'd0, 1, 32'd5, 32'd6, 1'b1);

    // Second start in cycle 5 must be ignored.
    applyStimulus(1'b0, 32'd3, 32'd5);
    repeat (4) step();
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd100;
    b     = 32'd0;
    step();
    start = 1'b0;
    n = cyc - t0 + 1;
    waitDone(n);
    checkOutput("repulse_cycle", 32'(n), 32'd33);
    checkOutput("repulse_hi", hi, 32'd0);
    checkOutput("repulse_lo", lo, 32'd15);
    checkOutput("repulse_div_zero", 32'(div_zero), 32'd0);
    step();

    // Reset in cycle 10 discards the operation.
    applyStimulus(1'b0, 32'd7, 32'd9);
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_hi", hi, 32'd0);
    checkOutput("midreset_lo", lo, 32'd0);
    repeat (30) step();
    runOp("post_reset", 1'b0, 32'd6, 32'd7, 33, 32'd0, 32'd42, 1'b0);

    repeat (2) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
